// File: rtl/ysyx_25060170_mem_arb.sv
// ysyx_25060170_mem_arb
// Two-to-one arbiter placing the IFU and the LSU on one data-memory port.
// Only one transaction is outstanding at a time. The request fields are
// captured in the grant cycle and held on mem_* until memory accepts them.
// When both requesters ask at once, the winner alternates so neither can
// starve the other. An IFU fetch that is flushed while in flight still
// completes downstream, but its data is never handed back to the IFU.

module ysyx_25060170_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req,
    input  logic [ADDR_W-1:0]     ifu_addr,
    input  logic                  ifu_flush,
    output logic                  ifu_gnt,
    output logic                  ifu_rvalid,
    output logic [DATA_W-1:0]     ifu_rdata,

    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_gnt,
    output logic                  lsu_rvalid,
    output logic [DATA_W-1:0]     lsu_rdata,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state;
    logic   owner_lsu;
    logic   last_lsu;
    logic   drop;
    logic   grant_ifu;
    logic   grant_lsu;

    // Pick a winner while idle; a flushing IFU is never granted, and reset forces both grants low.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE && rst) begin
            if (lsu_req && ifu_req && !ifu_flush) begin
                grant_ifu = last_lsu;
                grant_lsu = !last_lsu;
            end else if (lsu_req) begin
                grant_lsu = 1'b1;
            end else if (ifu_req && !ifu_flush) begin
                grant_ifu = 1'b1;
            end
        end
    end

    assign ifu_gnt = grant_ifu;
    assign lsu_gnt = grant_lsu;

    // Transaction FSM: capture on grant, present until accepted, then return the response to its owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner_lsu  <= 1'b0;
            last_lsu   <= 1'b0;
            drop       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            ifu_rvalid <= 1'b0;
            ifu_rdata  <= '0;
            lsu_rvalid <= 1'b0;
            lsu_rdata  <= '0;
        end else begin
            ifu_rvalid <= 1'b0;
            lsu_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (grant_lsu) begin
                        mem_req   <= 1'b1;
                        mem_we    <= lsu_we;
                        mem_addr  <= lsu_addr;
                        mem_wdata <= lsu_wdata;
                        mem_wstrb <= lsu_we ? lsu_wstrb : '0;
                        owner_lsu <= 1'b1;
                        last_lsu  <= 1'b1;
                        state     <= REQ;
                    end else if (grant_ifu) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= ifu_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        owner_lsu <= 1'b0;
                        last_lsu  <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (!owner_lsu && ifu_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!owner_lsu && ifu_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        if (owner_lsu) begin
                            lsu_rvalid <= 1'b1;
                            lsu_rdata  <= mem_we ? '0 : mem_rdata;
                        end else if (!drop && !ifu_flush) begin
                            ifu_rvalid <= 1'b1;
                            ifu_rdata  <= mem_rdata;
                        end
                        drop  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ysyx_25060170_mem_arb.md
Name: ysyx_25060170_mem_arb

Overview:
Two-to-one arbiter sharing the single data-memory port between the IFU (instruction fetch, read-only) and the LSU (64-bit lane-aligned load/store with 8-bit byte strobe).
- Serialises requests with one outstanding transaction at a time.
- Drives the downstream valid/ready request channel and routes the returned read data/ack back to the owning requester.
- Provides anti-starvation alternation and IFU fetch-flush discard.

Parameters:
ADDR_W, 32, address width of all request channels
DATA_W, 64, data width of read/write data; strobe width is DATA_W/8

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
ifu_req  in  1  IFU fetch request, held until ifu_gnt
ifu_addr  in  ADDR_W  fetch address
ifu_flush  in  1  discard any IFU transaction in flight
ifu_gnt  out  1  one-cycle pulse: IFU request latched
ifu_rvalid  out  1  one-cycle pulse: ifu_rdata valid
ifu_rdata  out  DATA_W  fetched data
lsu_req  in  1  LSU request, held until lsu_gnt
lsu_we  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_W  access address
lsu_wdata  in  DATA_W  lane-positioned store data
lsu_wstrb  in  DATA_W/8  byte strobe
lsu_gnt  out  1  one-cycle pulse: LSU request latched
lsu_rvalid  out  1  one-cycle pulse: load data valid / store complete
lsu_rdata  out  DATA_W  load data (0 for stores)
mem_req  out  1  downstream request valid
mem_we  out  1  downstream write enable
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream write data
mem_wstrb  out  DATA_W/8  downstream strobe (0 on reads)
mem_ready  in  1  downstream accepts request this cycle
mem_rvalid  in  1  downstream response valid (reads and writes)
mem_rdata  in  DATA_W  downstream read data

Behaviour:
Reset:
- rst low → state IDLE, owner/last_lsu/drop flags cleared.
- All outputs 0, including mem_* fields and rdata regs.
- Reset mid-transaction abandons it; a late mem_rvalid arriving in IDLE is ignored.

States:
- IDLE:
  - Arbitrate. If lsu_req and ifu_req both high: LSU wins unless last_lsu=1, in which case IFU wins.
  - A single requester wins outright.
  - IFU is not granted in a cycle where ifu_flush=1.
  - Winner gets a gnt pulse that cycle. Request fields are registered into mem_*; owner recorded; last_lsu <= (winner==LSU).
  - Next state is REQ. No request → stay IDLE.
- REQ:
  - mem_req=1 with stable fields.
  - mem_ready=1 → WAIT (mem_req drops next cycle).
  - mem_req is never retracted, even on flush.
- WAIT:
  - On mem_rvalid: register mem_rdata into the owner's rdata and pulse the owner's rvalid next cycle.
  - lsu_rdata is 0 for stores.
  - Next state IDLE.
  - mem_rvalid during REQ is illegal and is ignored.

Latency and throughput:
- Best case: gnt at T, mem_req T+1 (ready T+1), mem_rvalid T+2, rvalid T+3.
- IDLE is re-entered at T+3, so a new gnt may coincide with the previous rvalid pulse.

Flush:
- ifu_flush high while owner=IFU in REQ or WAIT sets drop.
- The transaction completes downstream, but ifu_rvalid is suppressed and ifu_rdata is unchanged.
- drop clears on return to IDLE.
- Flush has no effect on LSU transactions.

Other rules:
- gnt outputs are never both high.
- At most one rvalid pulse per grant.
- Requesters must hold req and fields stable until gnt. Fields are sampled only in the grant cycle.

Test Plan:
- Single LSU store: lsu_req, we=1, addr=0x8000_0008, wdata=0x00AB_0000_0000_0000, wstrb=0x40, mem_ready immediately, mem_rvalid next cycle → lsu_gnt at T; mem_req T+1 with identical fields; lsu_rvalid at T+3, lsu_rdata=0; ifu_gnt never high.
- Contention alternation: ifu_req and lsu_req held high continuously, zero-wait memory → grant order LSU, IFU, LSU, IFU; each rvalid goes to the correct owner; no back-to-back LSU grants while ifu_req pending.
- Backpressure: IFU fetch 0x8000_0000 with mem_ready low for 5 cycles → mem_req and mem_addr stable for 6 cycles; after mem_rvalid with rdata 0x0000_0013_0000_0093, ifu_rdata equals that value with one ifu_rvalid pulse.
- Flush discard: IFU transaction in WAIT, ifu_flush pulsed, mem_rvalid arrives → ifu_rvalid stays 0 and ifu_rdata unchanged; arbiter back in IDLE the following cycle and grants a pending lsu_req.
- Async reset mid-transaction: rst driven low between clock edges during REQ → all outputs 0 immediately; after release, a stray mem_rvalid produces no rvalid; next ifu_req is granted normally.
- Load return: lsu_req, we=0, addr=0x8000_0010, mem_rdata 0xDEAD_BEEF_0123_4567 → lsu_rdata matches exactly; mem_wstrb=0 during the request.
